// File: rtl/span_margin_combiner.sv
// Commodity margin combiner: scans a serial stream of scenario losses for the worst
// loss, folds in the inter-month spread charge and applies the short option minimum.
module span_margin_combiner #(
  parameter int NUM_SCEN = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        riskValid,
  input  logic [15:0] riskValue,
  output logic        riskReady,
  input  logic        tscDone,
  input  logic [15:0] tsc,
  input  logic [7:0]  shortOptCount,
  input  logic [7:0]  somRate,
  output logic        busy,
  output logic [15:0] scanRisk,
  output logic [16:0] margin,
  output logic        marginValid
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_WAIT_TSC,
    ST_COMBINE,
    ST_DONE
  } state_e;

  localparam logic [7:0]  LAST_IDX  = 8'(NUM_SCEN - 1);
  localparam logic [15:0] MOST_NEG  = 16'h8000;

  state_e      state_q;
  logic [15:0] max_loss_q;
  logic [7:0]  count_q;
  logic [15:0] tsc_q;
  logic        tsc_seen_q;
  logic        risk_ready_q;
  logic        busy_q;
  logic [15:0] scan_risk_q;
  logic [16:0] margin_q;
  logic        margin_valid_q;

  logic [15:0] scan_risk_d;
  logic [16:0] sum_d;
  logic [15:0] som_d;
  logic [16:0] margin_d;

  // Scanning risk is the worst loss floored at zero; the sum cannot exceed 17 bits.
  always_comb begin
    scan_risk_d = max_loss_q[15] ? 16'd0 : max_loss_q;
    sum_d       = {1'b0, scan_risk_d} + {1'b0, tsc_q};
    som_d       = shortOptCount * somRate;
    margin_d    = (sum_d >= {1'b0, som_d}) ? sum_d : {1'b0, som_d};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= ST_IDLE;
      max_loss_q     <= MOST_NEG;
      count_q        <= 8'd0;
      tsc_q          <= 16'd0;
      tsc_seen_q     <= 1'b0;
      risk_ready_q   <= 1'b0;
      busy_q         <= 1'b0;
      scan_risk_q    <= 16'd0;
      margin_q       <= 17'd0;
      margin_valid_q <= 1'b0;
    end else begin
      // Only the first done edge is latched so a level-held done keeps the original charge.
      if ((state_q == ST_COLLECT || state_q == ST_WAIT_TSC) && tscDone && !tsc_seen_q) begin
        tsc_q      <= tsc;
        tsc_seen_q <= 1'b1;
      end

      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q        <= ST_COLLECT;
            risk_ready_q   <= 1'b1;
            busy_q         <= 1'b1;
            max_loss_q     <= MOST_NEG;
            count_q        <= 8'd0;
            tsc_q          <= 16'd0;
            tsc_seen_q     <= 1'b0;
            margin_valid_q <= 1'b0;
          end
        end
        ST_COLLECT: begin
          if (riskValid) begin
            if ($signed(riskValue) > $signed(max_loss_q)) begin
              max_loss_q <= riskValue;
            end
            count_q <= count_q + 8'd1;
            if (count_q == LAST_IDX) begin
              state_q      <= ST_WAIT_TSC;
              risk_ready_q <= 1'b0;
            end
          end
        end
        ST_WAIT_TSC: begin
          if (tsc_seen_q || tscDone) begin
            state_q <= ST_COMBINE;
          end
        end
        ST_COMBINE: begin
          scan_risk_q    <= scan_risk_d;
          margin_q       <= margin_d;
          margin_valid_q <= 1'b1;
          busy_q         <= 1'b0;
          state_q        <= ST_DONE;
        end
        default: begin
          state_q      <= ST_IDLE;
          risk_ready_q <= 1'b0;
          busy_q       <= 1'b0;
        end
      endcase
    end
  end

  assign riskReady   = risk_ready_q;
  assign busy        = busy_q;
  assign scanRisk    = scan_risk_q;
  assign margin      = margin_q;
  assign marginValid = margin_valid_q;

endmodule
